// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: two-entry skid buffer between fetch and decode with
// valid/ready handshakes on both sides and MIPS field slicing of the held word.
module if_id_stage #(
    parameter int unsigned bus_instr = 32,
    parameter int unsigned bus_pc    = 32,
    parameter int unsigned bus_imm   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bus_instr-1:0] in_instr,
    input  logic [bus_pc-1:0]    in_pc4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bus_instr-1:0] out_instr,
    output logic [bus_pc-1:0]    out_pc4,
    output logic [5:0]           opcode,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           shamt,
    output logic [5:0]           funct,
    output logic [bus_imm-1:0]   inmediato
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [bus_instr-1:0] instr;
        logic [bus_pc-1:0]    pc4;
    } word_t;

    state_t state_q, state_d;
    word_t  main_q, main_d;
    word_t  skid_q, skid_d;
    word_t  in_word;
    logic   acc;
    logic   take;

    assign in_word   = '{instr: in_instr, pc4: in_pc4};
    assign in_ready  = (state_q != TWO) && !reset;
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    // State and storage registers; contents are dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and storage update; flush clears both entries to NOP.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_word;
                    end
                end
                ONE: begin
                    if (acc && take) begin
                        main_d = in_word;
                    end else if (acc) begin
                        state_d = TWO;
                        skid_d  = in_word;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (take) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign out_instr = main_q.instr;
    assign out_pc4   = main_q.pc4;
    assign opcode    = main_q.instr[31:26];
    assign rs        = main_q.instr[25:21];
    assign rt        = main_q.instr[20:16];
    assign rd        = main_q.instr[15:11];
    assign shamt     = main_q.instr[10:6];
    assign funct     = main_q.instr[5:0];
    assign inmediato = main_q.instr[bus_imm-1:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed steps plus randomized traffic checked
// against a queue-based model of the buffered words.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc4, out_instr, out_pc4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] inmediato;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mq[$];     // model: words held by the stage, head drives decode
    logic [63:0] sent[$];
    logic [63:0] got[$];

    always #5 clk = ~clk;

    if_id_stage #(.bus_instr(32), .bus_pc(32), .bus_imm(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .inmediato(inmediato)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, updating the model from the handshake rules.
    task automatic tick();
        bit acc, take;
        acc  = in_valid && !reset && (mq.size() < 2);
        take = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back({in_instr, in_pc4});
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] w;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'((mq.size() < 2) && !reset));
        if (mq.size() > 0) begin
            w = mq[0][63:32];
            chk({tag, ".instr"},  64'(out_instr), 64'(w));
            chk({tag, ".pc4"},    64'(out_pc4),   64'(mq[0][31:0]));
            chk({tag, ".opcode"}, 64'(opcode),    64'((w >> 26) & 32'h3f));
            chk({tag, ".rs"},     64'(rs),        64'((w >> 21) & 32'h1f));
            chk({tag, ".rt"},     64'(rt),        64'((w >> 16) & 32'h1f));
            chk({tag, ".rd"},     64'(rd),        64'((w >> 11) & 32'h1f));
            chk({tag, ".shamt"},  64'(shamt),     64'((w >> 6) & 32'h1f));
            chk({tag, ".funct"},  64'(funct),     64'(w & 32'h3f));
            chk({tag, ".imm"},    64'(inmediato), 64'(w & 32'hffff));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".zero_fields"},
            64'({opcode, rs, rt, rd, shamt, funct, inmediato}), 64'd0);
        chk({tag, ".zero_pc4"}, 64'(out_pc4), 64'd0);
        chk({tag, ".zero_instr"}, 64'(out_instr), 64'd0);
    endtask

    initial begin
        logic [31:0] word_a, word_b;
        int idx;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc4 = '0;

        // 1. reset held two cycles, then release
        tick(); tick();
        chk("rst.in_ready_low", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        #1;
        chk("rel.in_ready", 64'(in_ready), 64'd1);
        check_zero("rel");

        // 2. I-type word
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h2008FFFC; in_pc4 = 32'h4;
        tick();
        in_valid = 1'b0;
        chk("push1.out_valid", 64'(out_valid), 64'd1);
        chk("push1.opcode", 64'(opcode), 64'h08);
        chk("push1.rs", 64'(rs), 64'd0);
        chk("push1.rt", 64'(rt), 64'd8);
        chk("push1.imm", 64'(inmediato), 64'hFFFC);
        chk("push1.pc4", 64'(out_pc4), 64'h4);

        // 3. R-type word, previous word consumed in the same cycle
        in_valid = 1'b1; in_instr = 32'h012A4020; in_pc4 = 32'h8;
        tick();
        in_valid = 1'b0;
        chk("push2.opcode", 64'(opcode), 64'd0);
        chk("push2.rs", 64'(rs), 64'd9);
        chk("push2.rt", 64'(rt), 64'd10);
        chk("push2.rd", 64'(rd), 64'd8);
        chk("push2.shamt", 64'(shamt), 64'd0);
        chk("push2.funct", 64'(funct), 64'h20);
        check_model("push2");
        tick();
        chk("drain.out_valid", 64'(out_valid), 64'd0);

        // 4. back-pressure fills the skid entry
        word_a = 32'h8C430010; word_b = 32'hAC640024;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = word_a; in_pc4 = 32'hC;
        tick();
        in_instr = word_b; in_pc4 = 32'h10;
        tick();
        in_valid = 1'b0;
        chk("two.in_ready", 64'(in_ready), 64'd0);
        chk("two.head", 64'(out_instr), 64'(word_a));
        tick();
        chk("two.stable", 64'(out_instr), 64'(word_a));
        check_model("two");
        out_ready = 1'b1;
        tick();
        chk("two.second", 64'(out_instr), 64'(word_b));
        chk("two.second_pc4", 64'(out_pc4), 64'h10);
        tick();
        chk("two.empty", 64'(out_valid), 64'd0);

        // 5. flush while full with a word offered
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h11111111; in_pc4 = 32'h14; tick();
        in_instr = 32'h22222222; in_pc4 = 32'h18; tick();
        in_instr = 32'h33333333; in_pc4 = 32'h1C; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        check_zero("flush");
        tick(); tick();
        chk("flush.gone", 64'(out_valid), 64'd0);

        // 6. stream eight words with out_ready toggling
        sent.delete(); got.delete();
        for (int i = 0; i < 8; i++) sent.push_back({$urandom(), 32'(4 * (i + 1))});
        idx = 0;
        for (int c = 0; c < 80 && got.size() < 8; c++) begin
            in_valid  = (idx < 8);
            in_instr  = (idx < 8) ? sent[idx][63:32] : 32'h0;
            in_pc4    = (idx < 8) ? sent[idx][31:0]  : 32'h0;
            out_ready = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) got.push_back({out_instr, out_pc4});
            if (in_valid && in_ready) idx++;
            tick();
            check_model("stream");
        end
        in_valid = 1'b0;
        chk("stream.count", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("stream.word%0d", i), got[i], sent[i]);

        // reset mid-stream from the full state
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hDEADBEEF; in_pc4 = 32'h40; tick();
        in_instr = 32'hCAFEF00D; in_pc4 = 32'h44; tick();
        reset = 1'b1;
        tick();
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd0);
        check_zero("midrst");
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst.release", 64'(in_ready), 64'd1);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 59) == 0);
            in_instr  = $urandom();
            in_pc4    = $urandom() & 32'hFFFFFFFC;
            tick();
            flush = 1'b0; reset = 1'b0;
            #1;
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
